// File: rtl/crt_pkg.sv
// Shared definitions for the CRT sync blocks: pulse FSM encoding and the
// default timing constants (all in 1 us ticks).
package crt_pkg;

  typedef enum logic {
    S_HIGH = 1'b0,
    S_LOW  = 1'b1
  } pulse_state_t;

  localparam int DEF_GLITCH_US   = 1;
  localparam int DEF_HMAX_US     = 8;
  localparam int DEF_VMIN_US     = 16;
  localparam int DEF_LINE_MIN_US = 50;
  localparam int DEF_LINE_MAX_US = 80;
  localparam int DEF_VBROAD_N    = 3;
  localparam int DEF_LOCK_N      = 15;

endpackage

// File: rtl/crt_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin, followed by a registered
// previous-level compare that yields one-clk fall/rise strobes.
module crt_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q;

  // Flops clear to 0 so a pin that is low when reset lifts produces no fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign fall_o  = prev_q & ~sync2_q;
  assign rise_o  = ~prev_q & sync2_q;

endmodule

// File: rtl/crt_csyncsep.sv
// Composite-sync separator: classifies low pulses of csync_in by width,
// recovers H/V strobes, and measures line period, lines per field and lock.
module crt_csyncsep
  import crt_pkg::*;
#(
  parameter int GLITCH_US   = DEF_GLITCH_US,
  parameter int HMAX_US     = DEF_HMAX_US,
  parameter int VMIN_US     = DEF_VMIN_US,
  parameter int LINE_MIN_US = DEF_LINE_MIN_US,
  parameter int LINE_MAX_US = DEF_LINE_MAX_US,
  parameter int VBROAD_N    = DEF_VBROAD_N,
  parameter int LOCK_N      = DEF_LOCK_N
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       onemks,
  input  logic       csync_in,
  output logic       hs_stb,
  output logic       vs_stb,
  output logic       vsync,
  output logic [7:0] line_len,
  output logic [8:0] field_lines,
  output logic       locked
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [5:0]    GLITCH_W = 6'(GLITCH_US);
  localparam logic [5:0]    HMAX_W   = 6'(HMAX_US);
  localparam logic [5:0]    VMIN_W   = 6'(VMIN_US);
  localparam logic [7:0]    LMIN     = 8'(LINE_MIN_US);
  localparam logic [7:0]    LMAX     = 8'(LINE_MAX_US);
  localparam logic [2:0]    VBROAD_C = 3'(VBROAD_N);
  localparam logic [GW-1:0] LOCK_C   = GW'(LOCK_N);

  logic level, fall, rise;

  crt_edge_sync u_edge (
    .clk    (clk),
    .reset  (reset),
    .async_i(csync_in),
    .level_o(level),
    .fall_o (fall),
    .rise_o (rise)
  );

  pulse_state_t  state_q, state_d;
  logic [5:0]    width_q, width_d;
  logic [7:0]    per_q, per_d;
  logic [7:0]    since_q, since_d;
  logic [7:0]    lead_q, lead_d;
  logic [2:0]    broad_q, broad_d;
  logic [GW-1:0] good_q, good_d;
  logic [8:0]    lines_q, lines_d;
  logic [7:0]    len_q, len_d;
  logic [8:0]    field_q, field_d;
  logic          vsync_q, vsync_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HIGH;
      width_q <= '0;
      per_q   <= '0;
      since_q <= '0;
      lead_q  <= '0;
      broad_q <= '0;
      good_q  <= '0;
      lines_q <= '0;
      len_q   <= '0;
      field_q <= '0;
      vsync_q <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      per_q   <= per_d;
      since_q <= since_d;
      lead_q  <= lead_d;
      broad_q <= broad_d;
      good_q  <= good_d;
      lines_q <= lines_d;
      len_q   <= len_d;
      field_q <= field_d;
      vsync_q <= vsync_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    per_d   = per_q;
    since_d = since_q;
    lead_d  = lead_q;
    broad_d = broad_q;
    good_d  = good_q;
    lines_d = lines_q;
    len_d   = len_q;
    field_d = field_q;
    vsync_d = vsync_q;
    hs_d    = 1'b0;
    vs_d    = 1'b0;

    if (onemks && per_q != 8'hFF)          per_d   = per_q + 8'd1;
    if (onemks && since_q != 8'hFF)        since_d = since_q + 8'd1;
    if (onemks && !level && width_q != 6'd63) width_d = width_q + 6'd1;

    case (state_q)
      S_HIGH: begin
        if (fall) begin
          state_d = S_LOW;
          width_d = '0;
          lead_d  = per_q;
          since_d = {7'd0, onemks};
        end
      end
      S_LOW: begin
        // Classification uses the width held before this clk's tick.
        if (rise) begin
          state_d = S_HIGH;
          if (width_q > GLITCH_W && width_q <= HMAX_W) begin
            if (lead_q >= LMIN || vsync_q) begin
              hs_d    = 1'b1;
              len_d   = lead_q;
              lines_d = (lines_q == 9'h1FF) ? lines_q : lines_q + 9'd1;
              broad_d = '0;
              vsync_d = 1'b0;
              per_d   = (since_q == 8'hFF) ? since_q : since_q + {7'd0, onemks};
              if (lead_q >= LMIN && lead_q <= LMAX)
                good_d = (good_q == LOCK_C) ? good_q : good_q + GW'(1);
              else
                good_d = '0;
            end
          end else if (width_q > HMAX_W && width_q < VMIN_W) begin
            broad_d = '0;
          end else if (width_q >= VMIN_W) begin
            broad_d = (broad_q == 3'd7) ? broad_q : broad_q + 3'd1;
            if (broad_d == VBROAD_C && !vsync_q) begin
              vs_d    = 1'b1;
              vsync_d = 1'b1;
              field_d = lines_q;
              lines_d = '0;
            end
          end
        end
      end
    endcase

    // A saturated period means the sync source has gone away.
    if (per_q == 8'hFF) begin
      good_d  = '0;
      broad_d = '0;
      vsync_d = 1'b0;
    end
  end

  assign hs_stb      = hs_q;
  assign vs_stb      = vs_q;
  assign vsync       = vsync_q;
  assign line_len    = len_q;
  assign field_lines = field_q;
  assign locked      = (good_q == LOCK_C);

endmodule

// File: tb/tb_crt_csyncsep.sv
// Bench for crt_csyncsep: a pulse-level timestamp model predicts every output
// each cycle; directed literal checks pin the model at phase boundaries.
module tb_crt_csyncsep;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       onemks = 1'b0;
  logic       csync_in = 1'b1;
  logic       hs_stb, vs_stb, vsync, locked;
  logic [7:0] line_len;
  logic [8:0] field_lines;

  always #5 clk = ~clk;

  crt_csyncsep dut (
    .clk        (clk),
    .reset      (reset),
    .onemks     (onemks),
    .csync_in   (csync_in),
    .hs_stb     (hs_stb),
    .vs_stb     (vs_stb),
    .vsync      (vsync),
    .line_len   (line_len),
    .field_lines(field_lines),
    .locked     (locked)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int hs_seen  = 0;
  int vs_seen  = 0;

  // Model state, in microseconds. Each us is 3 clocks: pin changes on step 0,
  // onemks on step 1, and the DUT acts on a pin change at step 2.
  int us_now = 0;
  int acc_us = 0;      // leading edge of the last accepted H pulse
  int fall_us = 0;
  int lead_m = 0;
  int lines_m = 0;
  int good_m = 0;
  int broad_m = 0;
  int pend = 0;        // 0 none, 1 fall, 2 rise
  bit in_low = 1'b0;
  bit seen_lvl = 1'b0;
  logic       exp_hs = 1'b0, exp_vs = 1'b0, exp_vsync = 1'b0, exp_locked = 1'b0;
  logic [7:0] exp_line_len = '0;
  logic [8:0] exp_field = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, us=%0d)", name, act, req, $time, us_now);
    end
  endtask

  function automatic void classify_pulse(input int w);
    if (w <= 1) begin
      // glitch: nothing observable changes
    end else if (w <= 8) begin
      if (lead_m >= 50 || exp_vsync) begin
        exp_hs       = 1'b1;
        exp_line_len = 8'(lead_m);
        lines_m      = (lines_m < 511) ? lines_m + 1 : 511;
        broad_m      = 0;
        exp_vsync    = 1'b0;
        acc_us       = fall_us;
        if (lead_m >= 50 && lead_m <= 80) good_m = (good_m < 15) ? good_m + 1 : 15;
        else good_m = 0;
      end
    end else if (w < 16) begin
      broad_m = 0;
    end else begin
      broad_m = (broad_m < 7) ? broad_m + 1 : 7;
      if (broad_m == 3 && !exp_vsync) begin
        exp_vs    = 1'b1;
        exp_vsync = 1'b1;
        exp_field = 9'(lines_m);
        lines_m   = 0;
      end
    end
  endfunction

  function automatic void model_step(input int j, input bit rst, input bit lvl);
    int  ticks;
    bit  timed_out;
    exp_hs = 1'b0;
    exp_vs = 1'b0;
    if (rst) begin
      lines_m = 0; good_m = 0; broad_m = 0; pend = 0;
      in_low = 1'b0; seen_lvl = 1'b0;
      exp_vsync = 1'b0; exp_locked = 1'b0; exp_line_len = '0; exp_field = '0;
      acc_us = us_now;
      return;
    end
    if (j == 0 && lvl != seen_lvl) begin
      pend = lvl ? 2 : 1;
      seen_lvl = lvl;
    end
    ticks = us_now - acc_us - 1 + ((j > 1) ? 1 : 0);
    timed_out = (ticks >= 255);
    if (j == 2 && pend == 1) begin
      pend = 0;
      in_low = 1'b1;
      fall_us = us_now;
      lead_m = (us_now - acc_us > 255) ? 255 : us_now - acc_us;
    end else if (j == 2 && pend == 2) begin
      pend = 0;
      if (in_low) begin
        in_low = 1'b0;
        classify_pulse((us_now - fall_us > 63) ? 63 : us_now - fall_us);
      end
    end
    if (timed_out) begin
      good_m = 0;
      broad_m = 0;
      exp_vsync = 1'b0;
    end
    exp_locked = (good_m == 15);
  endfunction

  task automatic step(input int j, input bit rst, input bit lvl);
    @(negedge clk);
    reset  = rst;
    onemks = (j == 1);
    if (j == 0) csync_in = lvl;
    model_step(j, rst, lvl);
  endtask

  task automatic run_us(input bit lvl, input int n, input bit rst = 1'b0);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 3; j++) step(j, rst, lvl);
      us_now++;
    end
  endtask

  task automatic line(input int low_us, input int high_us);
    run_us(1'b0, low_us);
    run_us(1'b1, high_us);
  endtask

  always @(posedge clk) begin
    #1;
    check("hs_stb", hs_stb, exp_hs);
    check("vs_stb", vs_stb, exp_vs);
    check("vsync", vsync, exp_vsync);
    check("line_len", line_len, exp_line_len);
    check("field_lines", field_lines, exp_field);
    check("locked", locked, exp_locked);
    if (hs_stb === 1'b1) hs_seen++;
    if (vs_stb === 1'b1) vs_seen++;
  end

  initial begin
    int h0;
    int v0;
    run_us(1'b1, 2, 1'b1);
    check("reset_line_len", line_len, 0);
    run_us(1'b1, 63);

    // PAL lines: 4 us low, 64 us period
    for (int i = 0; i < 14; i++) line(4, 60);
    check("pal_locked_after_14", locked, 0);
    line(4, 60);
    check("pal_locked_after_15", locked, 1);
    for (int i = 0; i < 5; i++) line(4, 60);
    check("pal_hs_count", hs_seen, 20);
    check("pal_line_len", line_len, 64);

    // Equalizing pulses: only every other one lands on a line boundary
    h0 = hs_seen;
    for (int i = 0; i < 6; i++) line(2, 30);
    check("eq_hs_count", hs_seen - h0, 3);
    check("eq_line_len", line_len, 64);

    // Remaining lines of the field, some carrying a 1 us glitch
    h0 = hs_seen;
    for (int i = 0; i < 289; i++) begin
      if (i % 100 == 0) begin
        run_us(1'b0, 4); run_us(1'b1, 20); run_us(1'b0, 1); run_us(1'b1, 39);
      end else begin
        line(4, 60);
      end
    end
    check("glitch_hs_count", hs_seen - h0, 289);
    check("glitch_line_len", line_len, 64);
    check("glitch_locked", locked, 1);

    // Broad pulses
    h0 = hs_seen;
    v0 = vs_seen;
    for (int i = 0; i < 5; i++) line(27, 5);
    check("vert_vs_count", vs_seen - v0, 1);
    check("vert_hs_count", hs_seen - h0, 0);
    check("vert_field_lines", field_lines, 312);
    check("vert_vsync_high", vsync, 1);
    line(4, 60);
    check("vert_vsync_cleared", vsync, 0);
    check("vert_line_len", line_len, 224);
    check("vert_lock_lost", locked, 0);

    // Relock, then sync disappears
    for (int i = 0; i < 16; i++) line(4, 60);
    check("relock", locked, 1);
    run_us(1'b0, 4);
    run_us(1'b1, 236);
    check("timeout_not_yet", locked, 1);
    run_us(1'b1, 64);
    check("timeout_unlocked", locked, 0);
    check("timeout_line_len_held", line_len, 64);

    // Reset in the middle of a low pulse
    run_us(1'b0, 1);
    run_us(1'b0, 1, 1'b1);
    check("midpulse_reset_line_len", line_len, 0);
    check("midpulse_reset_field", field_lines, 0);
    run_us(1'b0, 1);
    h0 = hs_seen;
    run_us(1'b1, 63);
    check("post_reset_no_hs", hs_seen - h0, 0);
    line(4, 60);
    check("post_reset_hs_count", hs_seen - h0, 1);
    check("post_reset_line_len", line_len, 65);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crt_csyncsep.md
Name: crt_csyncsep

Overview:
Composite-sync separator and measurer, the receive-side counterpart of the CRT sync generator and sync inverter. Takes an external active-low composite sync (csync_in) and recovers horizontal and vertical timing strobes. Measures the line period and the number of lines per field, and reports lock status. Sits on the external sync path; its strobes feed the CPU measurement registers and the field interrupt.

Parameters:
GLITCH_US, 1, low pulses of this width (µs ticks) or less are ignored entirely
HMAX_US, 8, longest low width classified as a horizontal pulse
VMIN_US, 16, shortest low width classified as a broad (vertical) pulse
LINE_MIN_US, 50, minimum leading-edge-to-leading-edge period for an accepted H pulse
LINE_MAX_US, 80, maximum period counted as a good line for lock
VBROAD_N, 3, consecutive broad pulses needed to declare vertical sync
LOCK_N, 15, consecutive good lines needed to assert locked

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
onemks  in  1  one-clk strobe at 1 MHz; all timing is counted in these ticks
csync_in  in  1  asynchronous composite sync, active low
hs_stb  out  1  one-clk strobe at the trailing edge of each accepted H pulse
vs_stb  out  1  one-clk strobe when vertical sync is declared
vsync  out  1  level; high from vs_stb until the first accepted H pulse afterwards
line_len  out  8  period of the last accepted line, in µs
field_lines  out  9  accepted H pulses counted in the previous field
locked  out  1  stable line timing detected

Behaviour:
- Interface: clock port is clk; reset port is reset, synchronous and active-high. All state updates occur on the rising edge of clk.
- Input conditioning: csync_in passes through a 2-FF synchronizer, then a registered previous-level compare. A falling or rising edge is detected 3 clk after the pin changes.
- Counters:
  - width_cnt (6 bit) increments on onemks while the synced level is low and saturates at 63.
  - per_cnt (8 bit) increments on onemks always and saturates at 255.
- Pulse FSM, states S_HIGH and S_LOW:
  - S_HIGH → S_LOW on a falling edge. width_cnt is cleared. If onemks coincides with the edge, the clear wins.
  - S_LOW → S_HIGH on a rising edge. The pulse is classified on that clk using the width w:
    - w ≤ GLITCH_US: ignored; no counters change except width_cnt.
    - GLITCH_US < w ≤ HMAX_US: H candidate.
    - HMAX_US < w < VMIN_US: invalid; broad_cnt cleared.
    - w ≥ VMIN_US: broad pulse; broad_cnt incremented (saturates at 7).
- Leading-edge latch: the value of per_cnt at each non-glitch falling edge is held in lead_per. per_cnt restarts only on an accepted H pulse; the reload value is the ticks elapsed since the leading edge.
- H acceptance: an H candidate is accepted only if lead_per ≥ LINE_MIN_US, or if vsync=1. This rejects half-line equalizing pulses. On acceptance:
  - hs_stb=1 for one clk; line_len ← lead_per.
  - lines_acc increments, saturating at 511.
  - broad_cnt is cleared; vsync is cleared.
- Lock:
  - If LINE_MIN_US ≤ lead_per ≤ LINE_MAX_US, good_cnt increments (saturates at LOCK_N). locked=1 once good_cnt=LOCK_N.
  - An accepted H pulse outside that range clears good_cnt and locked.
- Vertical: when broad_cnt reaches VBROAD_N with vsync=0:
  - vs_stb=1 for one clk; vsync ← 1.
  - field_lines ← lines_acc, and lines_acc ← 0.
  - Further broad pulses in the same field do not re-strobe.
- Timeout: when per_cnt reaches 255, locked, good_cnt, broad_cnt and vsync are all cleared. line_len and field_lines are held.
- Simultaneous events:
  - Vertical detection and H acceptance cannot coincide, since one pulse has one class.
  - A rising edge in the same clk as onemks classifies using the pre-increment width.
- Reset: all outputs and internal counters go to 0 and the FSM goes to S_HIGH. This applies on any cycle, including mid-pulse. After reset, the first accepted H requires a complete falling/rising pair.

Decomposition:
- Package crt_pkg holds the FSM state encoding (S_HIGH/S_LOW) and the default timing constants above, shared with crt_scan and crt_syncsinv.
- One sub-module, crt_edge_sync: 2-FF synchronizer plus rise/fall strobes, instantiated once.

Test Plan:
- PAL-like stream, 4 µs low / 64 µs period × 20 lines → hs_stb every line, line_len=64, locked=1 after the 15th line.
- Equalizing pulses of 2 µs at 32 µs intervals → no hs_stb on the mid-line pulses; line_len unchanged.
- Five 27 µs broad pulses at 32 µs spacing after 312 lines → one vs_stb on the 3rd broad pulse, field_lines=312, vsync high until the next 4 µs pulse.
- Glitches of 1 µs inside a line → no hs_stb and no change to per_cnt or line_len.
- csync_in held high for 300 µs while locked → locked=0 by 255 µs after the last accepted H; line_len retained.
- reset asserted mid-pulse (csync low 3 µs), released, then a clean line → all outputs 0 during reset; first hs_stb only after a full pulse.
